hls_stream_fifo: RTL and testbench
==================================

Name: hls_stream_fifo

Overview:
- Parametrised successor to the single-width stream channel that connects HLS kernels to each other and to testbenches.
- Provides a DEPTH-entry FIFO of WIDTH-bit data words, each carrying a last-of-packet flag, using the same valid/ready naming as the existing stream.
- New over the fixed stream: occupancy and packet counters, almost-full threshold, synchronous flush, and an optional store-and-forward mode that exposes data only once a complete packet is buffered.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2); need not be a power of two.
- AFULL_LEVEL, 6, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH).
- STORE_FWD, 0, 1 = read side sees data only when at least one complete packet is stored.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data_bus  in  WIDTH  write data.
- in_last_bus  in  1  write last-of-packet flag.
- write_valid  in  1  writer offers a word.
- write_ready  out  1  FIFO can accept a word.
- data_bus  out  WIDTH  head-of-FIFO data.
- last_bus  out  1  head-of-FIFO last flag.
- read_ready  out  1  head word is valid and readable.
- read_valid  in  1  reader pops the head word.
- flush  in  1  synchronous clear of all contents.
- count  out  $clog2(DEPTH+1)  words currently stored.
- pkt_count  out  $clog2(DEPTH+1)  complete packets (stored last flags) currently held.
- almost_full  out  1  count >= AFULL_LEVEL.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr = rd_ptr = count = pkt_count = 0. While rst is low: write_ready = 0, read_ready = 0, data_bus = 0, last_bus = 0, almost_full = 0. Storage contents are not reset.
- write_ready = rst && (count < DEPTH).
  - No write pass-through when full: a write with a simultaneous read while full is refused.
- Base read_ready = (count != 0).
  - With STORE_FWD = 1, read_ready = (count != 0) && (pkt_count != 0).
- data_bus / last_bus: combinational from mem[rd_ptr] when read_ready = 1; driven 0 otherwise.
- Write fire = write_valid && write_ready. On the edge: mem[wr_ptr] <= {in_last_bus, in_data_bus}; wr_ptr advances.
- Read fire = read_valid && read_ready. On the edge: rd_ptr advances.
  - read_valid while read_ready = 0 is ignored, with no error.
- Latency:
  - A word written at edge N is visible on data_bus after edge N (cycle N+1) when not in store-and-forward mode.
  - With STORE_FWD = 1, it becomes visible the cycle after the edge that writes the packet's last word.
- Pointers: increment; wrap from DEPTH-1 to 0 explicitly, with no power-of-two assumption.
- count update:
  - +1 on write fire only.
  - -1 on read fire only.
  - Unchanged when both fire in the same cycle.
- pkt_count update:
  - +1 on write fire with in_last_bus = 1.
  - -1 on read fire with head last_bus = 1.
  - Unchanged when both occur together.
- Simultaneous read and write when count = 1: legal; the old head is popped and the new word becomes the head.
- flush (rst high): on the edge, pointers, count and pkt_count go to 0. flush overrides any concurrent read or write fire; neither takes effect.
- Store-and-forward deadlock: if the FIFO fills (count = DEPTH) with pkt_count = 0, it stalls until flush. This is a documented limitation; a packet must be <= DEPTH words.
- Reset asserted mid-packet: all state is lost immediately. Outputs take reset values asynchronously.

Decomposition:
- Shared package hls_stream_pkg:
  - Function for counter width, ceil log2 of (DEPTH+1).
  - Typedef/struct pairing last flag with data, parametrised by WIDTH.
- One natural sub-module, hls_stream_ram: a DEPTH x (WIDTH+1) register array with one write port and an asynchronous read port.
- Control (pointers, counters, flags) lives in hls_stream_fifo.

Test Plan:
- Basic packet, default params, STORE_FWD = 0: write 28, 10, 7, 3 (last on 3) on consecutive cycles with read_valid = 0 -> count = 4, pkt_count = 1, almost_full = 0. Then pulse read_valid on alternate cycles -> data_bus shows 28, 10, 7, 3 with last_bus 0, 0, 0, 1; count returns to 0 and read_ready = 0.
- Full / almost-full, DEPTH = 8, AFULL_LEVEL = 6: write 8 words 1..8 -> almost_full rises after the 6th write, write_ready = 0 after the 8th. A 9th write of 99 is refused. Reading all 8 returns 1..8, with no 99.
- Wrap and concurrent access, DEPTH = 5: stream 20 words 0..19 with write_valid and read_valid both held high -> output order 0..19 is preserved; count stays <= 1 and never exceeds DEPTH.
- Store-and-forward, STORE_FWD = 1: write 5, 6 (last = 0) -> read_ready stays 0. Write 7 (last = 1) -> read_ready = 1 on the next cycle with data_bus = 5; pkt_count = 1.
- Flush priority: hold 3 words, assert flush together with write_valid (data 42) and read_valid -> next cycle count = 0, pkt_count = 0, read_ready = 0, and 42 is not stored.
- Async reset mid-operation: with 4 words stored, drop rst between clock edges -> write_ready, read_ready, data_bus and count are 0 immediately. After release, a single write of 11 is read back as 11.

Source files
------------

// File: rtl/hls_stream_pkg.sv
// Shared definitions for the hls_stream FIFO family: counter sizing and
// the per-cycle access decode used by the occupancy counters.
package hls_stream_pkg;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bit 1 = write fire, bit 0 = read fire.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/hls_stream_ram.sv
// DEPTH x (WIDTH+1) register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module hls_stream_ram
    import hls_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WIDTH:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WIDTH:0] rdata
);

    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hls_stream_fifo.sv
// Valid/ready stream FIFO with last-of-packet flags, occupancy and packet
// counters, almost-full threshold, synchronous flush and store-and-forward.
module hls_stream_fifo
    import hls_stream_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 6,
    parameter bit          STORE_FWD   = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                in_data_bus,
    input  logic                            in_last_bus,
    input  logic                            write_valid,
    output logic                            write_ready,
    output logic [WIDTH-1:0]                data_bus,
    output logic                            last_bus,
    output logic                            read_ready,
    input  logic                            read_valid,
    input  logic                            flush,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic [cnt_width(DEPTH)-1:0]     pkt_count,
    output logic                            almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pkt_q;
    entry_t        wr_entry;
    entry_t        head;
    logic          wr_fire;
    logic          rd_fire;
    logic          pkt_inc;
    logic          pkt_dec;
    logic          head_avail;
    op_e           op;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign wr_entry = '{last: in_last_bus, data: in_data_bus};

    hls_stream_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire && !flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Store-and-forward hides the head until a whole packet is buffered.
    assign head_avail  = (count_q != '0) && (!STORE_FWD || (pkt_q != '0));
    assign write_ready = rst && (count_q < DEPTH_C);
    assign read_ready  = rst && head_avail;
    assign almost_full = rst && (count_q >= AFULL_C);
    assign data_bus    = read_ready ? head.data : '0;
    assign last_bus    = read_ready ? head.last : 1'b0;
    assign count       = count_q;
    assign pkt_count   = pkt_q;

    assign wr_fire = write_valid && write_ready;
    assign rd_fire = read_valid && read_ready;
    assign pkt_inc = wr_fire && in_last_bus;
    assign pkt_dec = rd_fire && head.last;
    assign op      = op_e'({wr_fire, rd_fire});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case (op)
                OP_WR:   count_q <= count_q + 1'b1;
                OP_RD:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_q <= pkt_q + 1'b1;
                2'b01:   pkt_q <= pkt_q - 1'b1;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_stream_fifo.sv
// Scoreboard bench for hls_stream_fifo: default, DEPTH=5 and store-and-forward
// instances, each with its own expected-word queue and read monitor.
module tb_hls_stream_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];

    // Instance A: default parameters
    logic [15:0] a_wd = '0;  logic a_wl = 0, a_wv = 0, a_rv = 0, a_fl = 0;
    logic [15:0] a_db;       logic a_lb, a_wr, a_rr, a_af;
    logic [3:0]  a_cnt, a_pc;
    // Instance B: DEPTH = 5
    logic [15:0] b_wd = '0;  logic b_wl = 0, b_wv = 0, b_rv = 0, b_fl = 0;
    logic [15:0] b_db;       logic b_lb, b_wr, b_rr, b_af;
    logic [2:0]  b_cnt, b_pc;
    // Instance C: store-and-forward
    logic [15:0] c_wd = '0;  logic c_wl = 0, c_wv = 0, c_rv = 0, c_fl = 0;
    logic [15:0] c_db;       logic c_lb, c_wr, c_rr, c_af;
    logic [3:0]  c_cnt, c_pc;

    hls_stream_fifo #(.WIDTH(16), .DEPTH(8), .AFULL_LEVEL(6), .STORE_FWD(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_data_bus(a_wd), .in_last_bus(a_wl),
        .write_valid(a_wv), .write_ready(a_wr), .data_bus(a_db), .last_bus(a_lb),
        .read_ready(a_rr), .read_valid(a_rv), .flush(a_fl), .count(a_cnt),
        .pkt_count(a_pc), .almost_full(a_af));

    hls_stream_fifo #(.WIDTH(16), .DEPTH(5), .AFULL_LEVEL(4), .STORE_FWD(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_data_bus(b_wd), .in_last_bus(b_wl),
        .write_valid(b_wv), .write_ready(b_wr), .data_bus(b_db), .last_bus(b_lb),
        .read_ready(b_rr), .read_valid(b_rv), .flush(b_fl), .count(b_cnt),
        .pkt_count(b_pc), .almost_full(b_af));

    hls_stream_fifo #(.WIDTH(16), .DEPTH(8), .AFULL_LEVEL(6), .STORE_FWD(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_data_bus(c_wd), .in_last_bus(c_wl),
        .write_valid(c_wv), .write_ready(c_wr), .data_bus(c_db), .last_bus(c_lb),
        .read_ready(c_rr), .read_valid(c_rv), .flush(c_fl), .count(c_cnt),
        .pkt_count(c_pc), .almost_full(c_af));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a read fires at the next edge, so compare the head against the queue.
    always @(negedge clk) begin
        if (a_rv && a_rr && !a_fl) begin
            if (qa.size() == 0) check("a_unexpected_read", 32'({a_lb, a_db}), 32'hFFFF_FFFF);
            else check("a_read_word", 32'({a_lb, a_db}), 32'(qa.pop_front()));
        end
        if (b_rv && b_rr && !b_fl) begin
            if (qb.size() == 0) check("b_unexpected_read", 32'({b_lb, b_db}), 32'hFFFF_FFFF);
            else check("b_read_word", 32'({b_lb, b_db}), 32'(qb.pop_front()));
        end
        if (c_rv && c_rr && !c_fl) begin
            if (qc.size() == 0) check("c_unexpected_read", 32'({c_lb, c_db}), 32'hFFFF_FFFF);
            else check("c_read_word", 32'({c_lb, c_db}), 32'(qc.pop_front()));
        end
    end

    task automatic wr_a(input logic [15:0] d, input logic l);
        a_wd = d; a_wl = l; a_wv = 1'b1;
        qa.push_back({l, d});
        step();
        a_wv = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] pkt [4];
        pkt[0] = 16'd28; pkt[1] = 16'd10; pkt[2] = 16'd7; pkt[3] = 16'd3;

        // Reset state
        #12;
        check("rst_write_ready", 32'(a_wr), 0);
        check("rst_read_ready",  32'(a_rr), 0);
        check("rst_data_bus",    32'(a_db), 0);
        check("rst_count",       32'(a_cnt), 0);
        check("rst_almost_full", 32'(a_af), 0);
        rst = 1'b1;
        step();
        check("post_rst_write_ready", 32'(a_wr), 1);

        // Basic packet 28,10,7,3 (last on 3)
        for (int i = 0; i < 4; i++) wr_a(pkt[i], i == 3);
        check("basic_count",       32'(a_cnt), 4);
        check("basic_pkt_count",   32'(a_pc), 1);
        check("basic_almost_full", 32'(a_af), 0);
        for (int i = 0; i < 4; i++) begin
            a_rv = 1'b1; step();
            a_rv = 1'b0; step();
        end
        check("basic_drain_count",      32'(a_cnt), 0);
        check("basic_drain_read_ready", 32'(a_rr), 0);
        check("basic_drain_pkt_count",  32'(a_pc), 0);

        // Full / almost-full
        for (int k = 1; k <= 8; k++) begin
            wr_a(16'(k), 1'b0);
            check("full_almost_full", 32'(a_af), (k >= 6) ? 1 : 0);
            check("full_write_ready", 32'(a_wr), (k < 8) ? 1 : 0);
        end
        a_wd = 16'd99; a_wl = 1'b0; a_wv = 1'b1;
        step();
        a_wv = 1'b0;
        check("full_refused_count", 32'(a_cnt), 8);
        a_rv = 1'b1;
        for (int i = 0; i < 8; i++) step();
        a_rv = 1'b0;
        check("full_drain_count", 32'(a_cnt), 0);

        // Wrap and concurrent access on DEPTH = 5
        b_rv = 1'b1; b_wv = 1'b1; b_wl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_wd = 16'(i);
            qb.push_back({1'b0, 16'(i)});
            step();
            check("wrap_count_le1", 32'(b_cnt <= 3'd1), 1);
        end
        b_wv = 1'b0;
        step();
        b_rv = 1'b0;
        check("wrap_final_count", 32'(b_cnt), 0);

        // Store-and-forward
        c_wv = 1'b1;
        c_wd = 16'd5; c_wl = 1'b0; qc.push_back({1'b0, 16'd5}); step();
        check("sf_hold_after_5", 32'(c_rr), 0);
        c_wd = 16'd6; c_wl = 1'b0; qc.push_back({1'b0, 16'd6}); step();
        check("sf_hold_after_6", 32'(c_rr), 0);
        c_wd = 16'd7; c_wl = 1'b1; qc.push_back({1'b1, 16'd7}); step();
        c_wv = 1'b0;
        check("sf_read_ready", 32'(c_rr), 1);
        check("sf_head_data",  32'(c_db), 5);
        check("sf_pkt_count",  32'(c_pc), 1);
        check("sf_count",      32'(c_cnt), 3);
        c_rv = 1'b1;
        for (int i = 0; i < 3; i++) step();
        c_rv = 1'b0;
        check("sf_drain_pkt_count",  32'(c_pc), 0);
        check("sf_drain_read_ready", 32'(c_rr), 0);

        // Flush priority over concurrent read and write
        wr_a(16'd1, 1'b0); wr_a(16'd2, 1'b0); wr_a(16'd3, 1'b1);
        check("flush_pre_count",     32'(a_cnt), 3);
        check("flush_pre_pkt_count", 32'(a_pc), 1);
        a_fl = 1'b1; a_wv = 1'b1; a_wd = 16'd42; a_wl = 1'b0; a_rv = 1'b1;
        step();
        a_fl = 1'b0; a_wv = 1'b0; a_rv = 1'b0;
        qa.delete();
        check("flush_count",       32'(a_cnt), 0);
        check("flush_pkt_count",   32'(a_pc), 0);
        check("flush_read_ready",  32'(a_rr), 0);
        check("flush_write_ready", 32'(a_wr), 1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) wr_a(16'(50 + i), 1'b0);
        check("arst_pre_count", 32'(a_cnt), 4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_write_ready", 32'(a_wr), 0);
        check("arst_read_ready",  32'(a_rr), 0);
        check("arst_data_bus",    32'(a_db), 0);
        check("arst_count",       32'(a_cnt), 0);
        check("arst_pkt_count",   32'(a_pc), 0);
        qa.delete();
        #3;
        rst = 1'b1;
        step();
        wr_a(16'd11, 1'b1);
        check("arst_single_read_ready", 32'(a_rr), 1);
        check("arst_single_head",       32'(a_db), 11);
        a_rv = 1'b1; step(); a_rv = 1'b0;
        check("arst_final_count", 32'(a_cnt), 0);

        step();
        check("qa_empty", 32'(qa.size()), 0);
        check("qb_empty", 32'(qb.size()), 0);
        check("qc_empty", 32'(qc.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
